// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/grant/response to data memory,
// store lane replication, load extension and pipeline stall.
module mem_stage_lsu #(
   parameter int RESP_TIMEOUT = 16,
   parameter int TO_W         = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] ReadDataM,
   output logic        done_o,
   output logic        StallM,
   output logic        misaligned_o,
   output logic        illegal_o,
   output logic        bus_err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT - 1);

   logic [1:0]      r_state;
   logic [TO_W-1:0] r_cnt;
   logic [1:0]      r_off;
   logic [2:0]      r_f3;
   logic            r_err;

   logic            w_idle;
   logic            w_one;
   logic            w_f3_ok;
   logic            w_aligned;
   logic            w_start;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic [31:0]     w_rfmt;

   assign w_idle = (r_state == S_IDLE);
   assign w_one  = MemReadM ^ MemWriteM;

   always_comb begin
      w_f3_ok = 1'b0;
      unique case (funct3M)
         3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
         3'b100, 3'b101:         w_f3_ok = MemReadM;
         default:                w_f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_aligned = 1'b1;
      unique case (funct3M[1:0])
         2'b00:   w_aligned = 1'b1;
         2'b01:   w_aligned = ~ALUResultM[0];
         default: w_aligned = (ALUResultM[1:0] == 2'b00);
      endcase
   end

   // Illegal wins over misaligned: misaligned only reported for legal funct3
   assign illegal_o    = w_idle & ((MemReadM & MemWriteM)
                                   | (w_one & ~w_f3_ok));
   assign misaligned_o = w_idle & w_one & w_f3_ok & ~w_aligned;
   assign w_start      = w_idle & w_one & w_f3_ok & w_aligned;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = WriteDataM;
      unique case (funct3M[1:0])
         2'b00: begin
            w_be    = 4'b0001 << ALUResultM[1:0];
            w_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = WriteDataM;
         end
      endcase
   end

   function automatic logic [31:0] fmt_load(
      input logic [2:0]  f3,
      input logic [1:0]  off,
      input logic [31:0] d
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = d[7:0];
      unique case (off)
         2'd0: b = d[7:0];
         2'd1: b = d[15:8];
         2'd2: b = d[23:16];
         2'd3: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      unique case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   assign w_rfmt = fmt_load(r_f3, r_off, dmem_rdata);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_off      <= '0;
         r_f3       <= '0;
         r_err      <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         ReadDataM  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= MemWriteM;
                  dmem_addr  <= {ALUResultM[31:2], 2'b00};
                  dmem_be    <= MemWriteM ? w_be : 4'b1111;
                  dmem_wdata <= MemWriteM ? w_wdata : 32'd0;
                  r_off      <= ALUResultM[1:0];
                  r_f3       <= funct3M;
                  r_err      <= 1'b0;
                  r_state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= dmem_we ? S_DONE : S_RESP;
               end
            end
            S_RESP: begin
               if (dmem_rvalid) begin
                  ReadDataM <= w_rfmt;
                  r_state   <= S_DONE;
               end else if (r_cnt == TO_LAST) begin
                  ReadDataM <= '0;
                  r_err     <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + TO_W'(1);
               end
            end
            S_DONE: begin
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign done_o    = (r_state == S_DONE);
   assign bus_err_o = done_o & r_err;
   assign StallM    = w_start | (r_state == S_REQ) | (r_state == S_RESP);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, loads, rejects,
// response timeout and reset mid-access.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        MemReadM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [31:0] ReadDataM;
   logic        done_o;
   logic        StallM;
   logic        misaligned_o;
   logic        illegal_o;
   logic        bus_err_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.RESP_TIMEOUT(16), .TO_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .ReadDataM(ReadDataM),
      .done_o(done_o), .StallM(StallM),
      .misaligned_o(misaligned_o), .illegal_o(illegal_o),
      .bus_err_o(bus_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
      MemReadM   = rd;
      MemWriteM  = wr;
      funct3M    = f3;
      ALUResultM = a;
      WriteDataM = wd;
   endtask

   task automatic clear_in();
      present(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".req"},   {31'd0, dmem_req}, 32'd0);
      chk({tag, ".stall"}, {31'd0, StallM},   32'd0);
      chk({tag, ".done"},  {31'd0, done_o},   32'd0);
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gap, input logic [31:0] ea,
                           input logic [3:0] ebe, input logic [31:0] ewd);
      present(1'b0, 1'b1, f3, a, wd);
      @(negedge clk);
      chk({tag, ".c0stall"}, {31'd0, StallM},   32'd1);
      chk({tag, ".c0req"},   {31'd0, dmem_req}, 32'd0);
      for (int i = 0; i < gap; i++) begin
         step();
         @(negedge clk);
         chk({tag, ".wreq"},   {31'd0, dmem_req}, 32'd1);
         chk({tag, ".waddr"},  dmem_addr,         ea);
         chk({tag, ".wbe"},    {28'd0, dmem_be},  {28'd0, ebe});
         chk({tag, ".wwd"},    dmem_wdata,        ewd);
         chk({tag, ".wstall"}, {31'd0, StallM},   32'd1);
      end
      step();
      dmem_gnt = 1'b1;
      @(negedge clk);
      chk({tag, ".req"},   {31'd0, dmem_req}, 32'd1);
      chk({tag, ".we"},    {31'd0, dmem_we},  32'd1);
      chk({tag, ".addr"},  dmem_addr,         ea);
      chk({tag, ".be"},    {28'd0, dmem_be},  {28'd0, ebe});
      chk({tag, ".wdata"}, dmem_wdata,        ewd);
      chk({tag, ".stall"}, {31'd0, StallM},   32'd1);
      step();
      dmem_gnt = 1'b0;
      @(negedge clk);
      chk({tag, ".done"},  {31'd0, done_o},   32'd1);
      chk({tag, ".dstl"},  {31'd0, StallM},   32'd0);
      chk({tag, ".dreq"},  {31'd0, dmem_req}, 32'd0);
      clear_in();
      step();
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rd,
                          input logic [31:0] exp);
      present(1'b1, 1'b0, f3, a, 32'h5555_5555);
      @(negedge clk);
      chk({tag, ".c0stall"}, {31'd0, StallM}, 32'd1);
      step();
      dmem_gnt = 1'b1;
      @(negedge clk);
      chk({tag, ".req"},  {31'd0, dmem_req}, 32'd1);
      chk({tag, ".we"},   {31'd0, dmem_we},  32'd0);
      chk({tag, ".addr"}, dmem_addr,         {a[31:2], 2'b00});
      chk({tag, ".be"},   {28'd0, dmem_be},  32'hF);
      chk({tag, ".wd"},   dmem_wdata,        32'd0);
      step();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = rd;
      @(negedge clk);
      chk({tag, ".rstall"}, {31'd0, StallM},   32'd1);
      chk({tag, ".rreq"},   {31'd0, dmem_req}, 32'd0);
      chk({tag, ".rdone"},  {31'd0, done_o},   32'd0);
      step();
      dmem_rvalid = 1'b0;
      @(negedge clk);
      chk({tag, ".done"},  {31'd0, done_o},    32'd1);
      chk({tag, ".data"},  ReadDataM,          exp);
      chk({tag, ".dstl"},  {31'd0, StallM},    32'd0);
      chk({tag, ".berr"},  {31'd0, bus_err_o}, 32'd0);
      clear_in();
      step();
   endtask

   initial begin
      rst_n       = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
      clear_in();
      @(negedge clk);
      chk_quiet("rst");
      chk("rst.addr", dmem_addr, 32'd0);
      chk("rst.be", {28'd0, dmem_be}, 32'd0);
      chk("rst.rdata", ReadDataM, 32'd0);
      chk("rst.berr", {31'd0, bus_err_o}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      do_store("sw", 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 0,
               32'h1000_0004, 4'b1111, 32'hDEAD_BEEF);
      do_store("sb", 3'b000, 32'h0000_0103, 32'h0000_00A5, 3,
               32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
      do_store("sh", 3'b001, 32'h0000_0042, 32'h1234_BEEF, 0,
               32'h0000_0040, 4'b1100, 32'hBEEF_BEEF);
      chk("post.done", {31'd0, done_o}, 32'd0);

      do_load("lb",  3'b000, 32'h0000_0202, 32'h0080_0000, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h0000_0202, 32'h0080_0000, 32'h0000_0080);
      do_load("lh",  3'b001, 32'h0000_0200, 32'h1234_8001, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h0000_0202, 32'h8001_0000, 32'h0000_8001);

      present(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0);
      @(negedge clk);
      chk("mis.pulse", {31'd0, misaligned_o}, 32'd1);
      chk("mis.ill", {31'd0, illegal_o}, 32'd0);
      chk_quiet("mis");
      clear_in();
      step();
      @(negedge clk);
      chk("mis.end", {31'd0, misaligned_o}, 32'd0);
      chk_quiet("mis2");

      step();
      present(1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h1);
      @(negedge clk);
      chk("ill.pulse", {31'd0, illegal_o}, 32'd1);
      chk("ill.mis", {31'd0, misaligned_o}, 32'd0);
      chk_quiet("ill");
      step();
      present(1'b1, 1'b0, 3'b110, 32'h0000_0002, 32'h0);
      @(negedge clk);
      chk("pri.ill", {31'd0, illegal_o}, 32'd1);
      chk("pri.mis", {31'd0, misaligned_o}, 32'd0);
      step();
      present(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0);
      @(negedge clk);
      chk("both.ill", {31'd0, illegal_o}, 32'd1);
      chk_quiet("both");
      clear_in();
      step();
      @(negedge clk);
      chk_quiet("ill.after");
      chk("ill.end", {31'd0, illegal_o}, 32'd0);

      step();
      present(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
      step();
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("to.wait", {30'd0, done_o, StallM}, 32'd1);
         step();
      end
      @(negedge clk);
      chk("to.done", {31'd0, done_o}, 32'd1);
      chk("to.berr", {31'd0, bus_err_o}, 32'd1);
      chk("to.data", ReadDataM, 32'd0);
      chk("to.stall", {31'd0, StallM}, 32'd0);
      clear_in();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h7777_7777;
      step();
      @(negedge clk);
      chk("late.data", ReadDataM, 32'd0);
      chk("late.berr", {31'd0, bus_err_o}, 32'd0);
      chk_quiet("late");
      step();
      dmem_rvalid = 1'b0;

      do_load("lw", 3'b010, 32'h0000_0404, 32'h1234_5678, 32'h1234_5678);

      present(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0);
      step();
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      @(negedge clk);
      chk("rr.stall", {31'd0, StallM}, 32'd1);
      clear_in();
      #1;
      rst_n = 1'b0;
      #1;
      chk_quiet("rr");
      chk("rr.addr", dmem_addr, 32'd0);
      chk("rr.be", {28'd0, dmem_be}, 32'd0);
      chk("rr.we", {31'd0, dmem_we}, 32'd0);
      chk("rr.rdata", ReadDataM, 32'd0);
      step();
      #1;
      rst_n = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hBAD0_BAD0;
      step();
      @(negedge clk);
      chk_quiet("rr.idle");
      chk("rr.ign", ReadDataM, 32'd0);
      step();
      dmem_rvalid = 1'b0;
      do_load("lw2", 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
